// File: rtl/wb_arb_pkg.sv
// Shared definitions for the register-file write-port arbiter.
// - Default data/address widths, shared with the pipeline stage registers.
// - Arbiter FSM state encoding.
package wb_arb_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int ADDR_W_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_STALL = 2'd2
    } arb_state_t;

endpackage

// File: rtl/wb_host_fifo.sv
// Synchronous FIFO holding queued host register writes as {addr, data}.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   push, din     write an entry (ignored when full)
//   pop           drop the head entry (ignored when empty)
//   head          current head entry (valid when !empty)
//   count         number of stored entries
//   full, empty   occupancy flags
module wb_host_fifo #(
    parameter int W     = 67,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  logic [W-1:0]            din,
    output logic [W-1:0]            head,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = (AW+1)'(1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; entries are only read once counted.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between the pipeline
// writeback stage and a queued host write channel. Pipeline writes win;
// host writes drain in idle WB cycles, and a host entry that sits through
// MAX_WAIT pipeline grants forces a one-cycle pipeline stall.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   wb_wen/wb_waddr/wb_wdata       pipeline writeback request
//   host_valid/addr/data, ready    host write handshake into the queue
//   rf_wen/rf_waddr/rf_wdata       registered register-file write port
//   stall_req                      registered one-cycle pipeline freeze
//   fifo_count                     queued host writes
//   collision_err                  sticky: pipeline wrote during a stall
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_WAIT   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wb_wen,
    input  logic [ADDR_W-1:0]            wb_waddr,
    input  logic [DATA_W-1:0]            wb_wdata,
    input  logic                         host_valid,
    input  logic [ADDR_W-1:0]            host_addr,
    input  logic [DATA_W-1:0]            host_data,
    output logic                         host_ready,
    output logic                         rf_wen,
    output logic [ADDR_W-1:0]            rf_waddr,
    output logic [DATA_W-1:0]            rf_wdata,
    output logic                         stall_req,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         collision_err
);

    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int WCW = $clog2(MAX_WAIT) + 1;

    arb_state_t                 state;
    logic [WCW-1:0]             wait_cnt;
    logic [ADDR_W+DATA_W-1:0]   fifo_head;
    logic                       fifo_full, fifo_empty;
    logic                       push, pipe_gnt, host_gnt;
    logic [CW-1:0]              cnt_after;

    // Full is exactly fifo_count == FIFO_DEPTH, from the registered count.
    assign host_ready = !fifo_full;
    assign push       = host_valid && host_ready;

    // A stall cycle ignores wb_wen, so the host head always wins there.
    assign pipe_gnt   = wb_wen && !stall_req;
    assign host_gnt   = !pipe_gnt && !fifo_empty;

    // Occupancy after this edge; drives the empty/non-empty FSM transitions.
    assign cnt_after  = fifo_count + CW'(push) - CW'(host_gnt);

    wb_host_fifo #(
        .W     (ADDR_W + DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (host_gnt),
        .din   ({host_addr, host_data}),
        .head  (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            wait_cnt      <= '0;
            stall_req     <= 1'b0;
            rf_wen        <= 1'b0;
            rf_waddr      <= '0;
            rf_wdata      <= '0;
            collision_err <= 1'b0;
        end else begin
            // Write port: address/data hold when nothing is granted.
            if (pipe_gnt) begin
                rf_wen   <= 1'b1;
                rf_waddr <= wb_waddr;
                rf_wdata <= wb_wdata;
            end else if (host_gnt) begin
                rf_wen   <= 1'b1;
                rf_waddr <= fifo_head[DATA_W +: ADDR_W];
                rf_wdata <= fifo_head[DATA_W-1:0];
            end else begin
                rf_wen   <= 1'b0;
            end

            if (wb_wen && stall_req) collision_err <= 1'b1;

            case (state)
                ST_IDLE: begin
                    wait_cnt <= '0;
                    if (cnt_after != '0) state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt_after == '0) begin
                        state    <= ST_IDLE;
                        wait_cnt <= '0;
                    end else if (host_gnt) begin
                        wait_cnt <= '0;
                    end else if (pipe_gnt) begin
                        // Starvation limit hit: freeze the pipeline for one cycle.
                        if (wait_cnt == WCW'(MAX_WAIT - 1)) begin
                            state     <= ST_STALL;
                            stall_req <= 1'b1;
                            wait_cnt  <= '0;
                        end else begin
                            wait_cnt  <= wait_cnt + WCW'(1);
                        end
                    end
                end
                ST_STALL: begin
                    stall_req <= 1'b0;
                    wait_cnt  <= '0;
                    state     <= (cnt_after != '0) ? ST_WAIT : ST_IDLE;
                end
                default: begin
                    state     <= ST_IDLE;
                    stall_req <= 1'b0;
                    wait_cnt  <= '0;
                end
            endcase
        end
    end

endmodule
